ctrl_fsm: RTL
=============

Name: ctrl_fsm

Overview:
- Multi-cycle control unit for the 16-bit processor, sitting directly downstream of the instruction memory (consumes `iout`) and upstream of pc, register_file, alu and datmem.
- Captures each instruction into an internal IR and sequences it through FETCH/DECODE/EXEC/MEM/WB.
- Drives every datapath enable and select, so that datapath becomes instruction-driven rather than free-running.

Parameters:
- DW, 16, instruction/data width.
- IAW, 9, instruction address width (matches pc).
- ALU_SUB, 3'd1, aluc code used for BEQ compare; `zero`=1 when operands are equal.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr  in  DW  instruction word from inmem at current PC.
- zero  in  1  ALU zero flag.
- ir_q  out  DW  latched instruction register.
- pc_en  out  1  PC load strobe, one cycle per instruction.
- pc_sel  out  2  PC source: 0 = PC+1, 1 = PC+sext(ir[11:8]), 2 = ir[8:0].
- ra_adr, rb_adr, rc_adr  out  4 each  register file addresses.
- wen  out  1  register-file write enable.
- wb_sel  out  1  writeback source: 0 = ALU `y`, 1 = datmem `dout`.
- aluc  out  3  ALU operation.
- rwb  out  1  datmem: 1 = read, 0 = write.
- dadd_sel  out  1  1 = datmem address taken from ir[7:0].
- halted  out  1  high while in HALT.

Behaviour:
- Encoding:
  - op = ir[15:12], rc = ir[11:8], ra = ir[7:4], rb = ir[3:0].
  - op 0-7: ALU, aluc = op[2:0], rc <= ra op rb.
  - op 8: LD, rc <= mem[ir[7:0]].
  - op 9: ST, mem[ir[7:0]] <= reg[rc].
  - op A: BEQ, if reg[ra]==reg[rb] then PC += sext(ir[11:8]).
  - op B: JMP, PC <= ir[8:0].
  - op C-E: NOP.
  - op F: HALT.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encoded in 3 bits.
- Outputs are a Moore decode of (state, ir_q). There is no combinational path from `instr` or `zero` to outputs, except pc_sel in EXEC for BEQ, which uses `zero`.
- FETCH: ir_q <= instr at the edge. Next state is DECODE.
- DECODE: ra_adr/rb_adr/rc_adr driven from ir_q; these stay driven from ir_q in all later states of the instruction. Next state:
  - ALU, BEQ → EXEC.
  - LD, ST → MEM.
  - JMP, NOP → FETCH with pc_en=1. pc_sel=2 for JMP, 0 for NOP.
  - HALT → HALT.
- EXEC:
  - ALU: aluc = op[2:0]. Next state is WB.
  - BEQ: aluc = ALU_SUB, pc_en=1, pc_sel = zero ? 1 : 0. Next state is FETCH.
- MEM: dadd_sel=1.
  - LD: rwb=1. Next state is WB.
  - ST: rwb=0 for exactly this one cycle, pc_en=1, pc_sel=0. Next state is FETCH.
- WB: wen=1, pc_en=1, pc_sel=0. wb_sel = 1 for LD, 0 for ALU. aluc held from EXEC. Next state is FETCH.
- HALT: sticky. All strobes are 0 and halted=1. Only rst exits.
- Latency in cycles:
  - ALU = 4, LD = 4.
  - ST = 3, BEQ = 3.
  - JMP = 2, NOP = 2.
  - HALT: enters after 2.
- Strobe rules:
  - wen, pc_en and rwb=0 are each asserted for at most one cycle per instruction.
  - wen and rwb=0 never assert in the same cycle.
- Default output values (outside the cases above, and on reset): pc_en=0, wen=0, rwb=1, pc_sel=0, wb_sel=0, dadd_sel=0, aluc=0, halted=0.
- Reset: state <= FETCH, ir_q <= 0, outputs take the defaults. rst asserted mid-instruction aborts it: no wen, pc_en or write strobe in that cycle, and FETCH on the next cycle. rst has priority over HALT.
- Branch offset: sext of 4 bits to IAW, two's complement; wrap-around of PC is pc's responsibility.
- rc = r0 writes are permitted; the controller does not special-case any register.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants: OP_LD=4'h8, OP_ST=4'h9, OP_BEQ=4'hA, OP_JMP=4'hB, OP_HALT=4'hF.
  - state encodings.
  - pc_sel encodings PCS_INC/PCS_BR/PCS_JMP.
- Sub-module ctrl_decode is natural: combinational (state, ir_q, zero) → outputs. ctrl_fsm keeps the state register, IR and next-state logic.

Test Plan:
- rst=1 two cycles, then instr=16'h1321 (op1, rc=3, ra=2, rb=1) → ir_q=16'h1321 after FETCH; aluc=1 in EXEC; wen=1, wb_sel=0, pc_en=1, pc_sel=0 in WB (cycle 4 after rst release); back to FETCH.
- instr=16'h8504 (LD r5, [4]) → MEM: rwb=1, dadd_sel=1; WB: wen=1, wb_sel=1, rc_adr=5. instr=16'h9604 (ST r6) → rwb=0 for exactly 1 cycle, wen never 1, pc_en with pc_sel=0.
- instr=16'hAE21 (BEQ offset -2): zero=1 → pc_sel=1, pc_en=1 in EXEC. Repeat with zero=0 → pc_sel=0. Total 3 cycles each.
- instr=16'hB123 (JMP 0x123) → DECODE: pc_en=1, pc_sel=2, ir_q[8:0]=9'h123. instr=16'hC000 → 2-cycle NOP, pc_sel=0.
- instr=16'hF000 → halted=1 from cycle 3, and stays 1 for 10 cycles with instr changing and no strobes. Then rst=1 → halted=0, FETCH.
- rst pulsed during WB of an ALU instruction → wen=0 and pc_en=0 in that cycle, ir_q=0, next instruction fetched normally.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle controller.
//   - opcode constants for the non-ALU instructions
//   - FSM state encoding (3 bits)
//   - PC source select encodings
//   - branch offset sign-extension helper (4-bit offset to PC width)
package ctrl_pkg;

   localparam int unsigned IAW = 9;

   localparam logic [3:0] OP_LD   = 4'h8;
   localparam logic [3:0] OP_ST   = 4'h9;
   localparam logic [3:0] OP_BEQ  = 4'hA;
   localparam logic [3:0] OP_JMP  = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [1:0] PCS_INC = 2'd0;
   localparam logic [1:0] PCS_BR  = 2'd1;
   localparam logic [1:0] PCS_JMP = 2'd2;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   function automatic logic [IAW-1:0] sext_off(input logic [3:0] off);
      return {{(IAW-4){off[3]}}, off};
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational output decode of (state, ir_q, zero).
// Ports:
//   rst      in   forces all strobes/selects to defaults (aborts current instr)
//   state    in   current FSM state
//   ir_q     in   latched instruction register
//   zero     in   ALU zero flag (used only for BEQ in EXEC)
//   pc_en, pc_sel, ra_adr, rb_adr, rc_adr, wen, wb_sel, aluc,
//   rwb, dadd_sel, halted   out   datapath controls
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter logic [2:0] ALU_SUB = 3'd1
) (
   input  logic        rst,
   input  state_t      state,
   input  logic [15:0] ir_q,
   input  logic        zero,
   output logic        pc_en,
   output logic [1:0]  pc_sel,
   output logic [3:0]  ra_adr,
   output logic [3:0]  rb_adr,
   output logic [3:0]  rc_adr,
   output logic        wen,
   output logic        wb_sel,
   output logic [2:0]  aluc,
   output logic        rwb,
   output logic        dadd_sel,
   output logic        halted
);

   logic [3:0] w_op;
   assign w_op = ir_q[15:12];

   always_comb begin
      pc_en    = 1'b0;
      pc_sel   = PCS_INC;
      wen      = 1'b0;
      wb_sel   = 1'b0;
      aluc     = '0;
      rwb      = 1'b1;
      dadd_sel = 1'b0;
      halted   = 1'b0;
      ra_adr   = ir_q[7:4];
      rb_adr   = ir_q[3:0];
      rc_adr   = ir_q[11:8];
      // rst gates the strobes combinationally so an aborted instruction
      // produces no side effects in the reset cycle itself.
      if (!rst) begin
         case (state)
            S_DECODE: begin
               if (w_op == OP_JMP) begin
                  pc_en  = 1'b1;
                  pc_sel = PCS_JMP;
               end else if (w_op[3] && w_op != OP_LD && w_op != OP_ST &&
                            w_op != OP_BEQ && w_op != OP_HALT) begin
                  pc_en  = 1'b1;
               end
            end
            S_EXEC: begin
               if (w_op == OP_BEQ) begin
                  aluc   = ALU_SUB;
                  pc_en  = 1'b1;
                  pc_sel = zero ? PCS_BR : PCS_INC;
               end else begin
                  aluc   = w_op[2:0];
               end
            end
            S_MEM: begin
               dadd_sel = 1'b1;
               if (w_op == OP_ST) begin
                  rwb   = 1'b0;
                  pc_en = 1'b1;
               end
            end
            S_WB: begin
               wen   = 1'b1;
               pc_en = 1'b1;
               if (w_op == OP_LD) wb_sel = 1'b1;
               else               aluc   = w_op[2:0];
            end
            S_HALT: halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle controller for the 16-bit processor.
// Holds the state register, instruction register and next-state logic;
// output decode lives in ctrl_decode.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   instr  [DW]     instruction word from instruction memory
//   zero            ALU zero flag
//   ir_q   [DW]     latched instruction register
//   pc_en, pc_sel   PC load strobe and source select
//   ra/rb/rc_adr    register file addresses
//   wen, wb_sel     register write enable and writeback source
//   aluc            ALU operation
//   rwb, dadd_sel   data memory read/write and address source
//   halted          high while in HALT
module ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned DW      = 16,
   parameter logic [2:0]  ALU_SUB = 3'd1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] instr,
   input  logic          zero,
   output logic [DW-1:0] ir_q,
   output logic          pc_en,
   output logic [1:0]    pc_sel,
   output logic [3:0]    ra_adr,
   output logic [3:0]    rb_adr,
   output logic [3:0]    rc_adr,
   output logic          wen,
   output logic          wb_sel,
   output logic [2:0]    aluc,
   output logic          rwb,
   output logic          dadd_sel,
   output logic          halted
);

   state_t          r_state;
   state_t          w_next;
   logic [DW-1:0]   r_ir;
   logic [3:0]      w_op;

   assign ir_q = r_ir;
   assign w_op = r_ir[DW-1 -: 4];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_ir    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH) r_ir <= instr;
      end
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            if (!w_op[3] || w_op == OP_BEQ)         w_next = S_EXEC;
            else if (w_op == OP_LD || w_op == OP_ST) w_next = S_MEM;
            else if (w_op == OP_HALT)                w_next = S_HALT;
            else                                     w_next = S_FETCH;
         end
         S_EXEC:   w_next = (w_op == OP_BEQ) ? S_FETCH : S_WB;
         S_MEM:    w_next = (w_op == OP_LD) ? S_WB : S_FETCH;
         S_WB:     w_next = S_FETCH;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_FETCH;
      endcase
   end

   ctrl_decode #(
      .ALU_SUB (ALU_SUB)
   ) u_decode (
      .rst      (rst),
      .state    (r_state),
      .ir_q     (r_ir[15:0]),
      .zero     (zero),
      .pc_en    (pc_en),
      .pc_sel   (pc_sel),
      .ra_adr   (ra_adr),
      .rb_adr   (rb_adr),
      .rc_adr   (rc_adr),
      .wen      (wen),
      .wb_sel   (wb_sel),
      .aluc     (aluc),
      .rwb      (rwb),
      .dadd_sel (dadd_sel),
      .halted   (halted)
   );

endmodule
